// File: rtl/mu0_run_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mu0_run_pkg
// Purpose  : Shared types and constants for the MU0 run controller: FSM state
//            encoding and MU0 bus / write-counter widths.
// Revision : 1.0 - initial release
// ============================================================================
package mu0_run_pkg;

    localparam int ADDR_W  = 12;   // MU0 address bus width
    localparam int DATA_W  = 16;   // MU0 data bus width
    localparam int WRCNT_W = 16;   // write-strobe counter width

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        RST_CORE = 2'd1,
        RUN      = 2'd2,
        DONE     = 2'd3
    } state_t;

endpackage
`default_nettype wire

// File: rtl/mu0_sat_counter.sv
`default_nettype none
// ============================================================================
// Module   : mu0_sat_counter
// Purpose  : Up-counter with synchronous clear, count enable and saturation at
//            all-ones (never wraps).
// Ports    : clk   - clock, rising edge
//            rst_n - asynchronous active-low reset (count -> 0)
//            clr   - synchronous clear, wins over en
//            en    - increment enable
//            count - current count value
// Revision : 1.0 - initial release
// ============================================================================
module mu0_sat_counter #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             en,
    output logic [WIDTH-1:0] count
);

    localparam logic [WIDTH-1:0] CNT_MAX = {WIDTH{1'b1}};
    localparam logic [WIDTH-1:0] CNT_ONE = {{(WIDTH-1){1'b0}}, 1'b1};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (en && (count != CNT_MAX)) begin
            count <= count + CNT_ONE;
        end
    end

endmodule
`default_nettype wire

// File: rtl/mu0_run_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : mu0_run_ctrl
// Purpose  : Run controller for the MU0 core. Holds the core in reset, releases
//            it RESET_CYCLES+1 edges after a start pulse, then watches halted
//            and the memory bus until the run ends by halt or timeout.
// Ports    : Clk, Reset (async, active-low)
//            start            - single-cycle run request (IDLE/DONE only)
//            halted, wr, addr - MU0 Halted / Wr / Addr
//            core_reset       - drives MU0 Reset (active-high)
//            running, done    - state flags
//            timeout          - run ended by TIMEOUT (valid while done)
//            cycles, writes   - saturating RUN-cycle / write-strobe counts
//            last_wr_addr     - address of the most recent write in RUN
// Option   : MU0_RUN_CTRL_BREAKPOINT_EN adds bp_valid, bp_addr, bp_hit; an
//            address match in RUN ends the run (priority below halted, above
//            timeout).
// Revision : 1.0 - initial release
// ============================================================================
module mu0_run_ctrl
    import mu0_run_pkg::*;
#(
    parameter int RESET_CYCLES = 2,
    parameter int CNT_W        = 16,
    parameter int TIMEOUT      = 1000
) (
    input  logic               Clk,
    input  logic               Reset,
    input  logic               start,
    input  logic               halted,
    input  logic               wr,
    input  logic [ADDR_W-1:0]  addr,
    output logic               core_reset,
    output logic               running,
    output logic               done,
    output logic               timeout,
    output logic [CNT_W-1:0]   cycles,
    output logic [WRCNT_W-1:0] writes,
    output logic [ADDR_W-1:0]  last_wr_addr
`ifdef MU0_RUN_CTRL_BREAKPOINT_EN
    ,
    input  logic               bp_valid,
    input  logic [ADDR_W-1:0]  bp_addr,
    output logic               bp_hit
`endif
);

    localparam int              RC_W     = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;
    localparam logic [RC_W-1:0] RC_LOAD  = RC_W'(RESET_CYCLES - 1);
    localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT - 1);

    state_t          state;
    logic [RC_W-1:0] rst_cnt;
    logic            in_run;
    logic            cnt_clr;
    logic            cyc_en;
    logic            wr_en;
    logic            tmo_hit;
    logic            bp_match;

    assign in_run  = (state == RUN);
    // start is only honoured in IDLE/DONE; the same edge clears all results.
    assign cnt_clr = start && ((state == IDLE) || (state == DONE));
    assign tmo_hit = (cycles == TMO_LAST);
    // The timeout edge still increments so cycles ends at exactly TIMEOUT;
    // halt and breakpoint edges do not count.
    assign cyc_en  = in_run && !halted && !bp_match;
    // Writes are captured on every RUN edge, including the terminating one.
    assign wr_en   = in_run && wr;

`ifdef MU0_RUN_CTRL_BREAKPOINT_EN
    assign bp_match = bp_valid && (addr == bp_addr);

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            bp_hit <= 1'b0;
        end else if (cnt_clr) begin
            bp_hit <= 1'b0;
        end else if (in_run && !halted && bp_match) begin
            bp_hit <= 1'b1;
        end
    end
`else
    assign bp_match = 1'b0;
`endif

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state      <= IDLE;
            rst_cnt    <= '0;
            core_reset <= 1'b1;
            running    <= 1'b0;
            done       <= 1'b0;
            timeout    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    core_reset <= 1'b1;
                    if (start) begin
                        state   <= RST_CORE;
                        rst_cnt <= RC_LOAD;
                        timeout <= 1'b0;
                    end
                end
                RST_CORE: begin
                    // Holding core_reset here also clears a halted flag left
                    // over from the previous run before RUN samples it.
                    if (rst_cnt == '0) begin
                        state      <= RUN;
                        core_reset <= 1'b0;
                        running    <= 1'b1;
                    end else begin
                        rst_cnt <= rst_cnt - 1'b1;
                    end
                end
                RUN: begin
                    if (halted || bp_match || tmo_hit) begin
                        state   <= DONE;
                        running <= 1'b0;
                        done    <= 1'b1;
                        timeout <= !halted && !bp_match;
                    end
                end
                DONE: begin
                    // Core stays out of reset so its halted state is visible.
                    if (start) begin
                        state      <= RST_CORE;
                        rst_cnt    <= RC_LOAD;
                        core_reset <= 1'b1;
                        done       <= 1'b0;
                        timeout    <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            last_wr_addr <= '0;
        end else if (cnt_clr) begin
            last_wr_addr <= '0;
        end else if (wr_en) begin
            last_wr_addr <= addr;
        end
    end

    mu0_sat_counter #(.WIDTH(CNT_W)) u_cycles (
        .clk   (Clk),
        .rst_n (Reset),
        .clr   (cnt_clr),
        .en    (cyc_en),
        .count (cycles)
    );

    mu0_sat_counter #(.WIDTH(WRCNT_W)) u_writes (
        .clk   (Clk),
        .rst_n (Reset),
        .clr   (cnt_clr),
        .en    (wr_en),
        .count (writes)
    );

endmodule
`default_nettype wire

// File: tb/tb_mu0_run_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_mu0_run_ctrl
// Purpose  : Directed self-checking bench for mu0_run_ctrl. MU0 and its memory
//            are represented by hand-driven halted / wr / addr sequences.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_mu0_run_ctrl;

    localparam int RESET_CYCLES = 2;
    localparam int CNT_W        = 16;
    localparam int TIMEOUT      = 50;

    logic        Clk    = 1'b0;
    logic        Reset  = 1'b1;
    logic        start  = 1'b0;
    logic        halted = 1'b0;
    logic        wr     = 1'b0;
    logic [11:0] addr   = 12'h000;
    logic        core_reset, running, done, timeout;
    logic [15:0] cycles, writes;
    logic [11:0] last_wr_addr;
`ifdef MU0_RUN_CTRL_BREAKPOINT_EN
    logic        bp_valid = 1'b0;
    logic [11:0] bp_addr  = 12'h000;
    logic        bp_hit;
`endif

    int n_pass  = 0;
    int n_total = 0;

    always #5 Clk = ~Clk;

    mu0_run_ctrl #(
        .RESET_CYCLES (RESET_CYCLES),
        .CNT_W        (CNT_W),
        .TIMEOUT      (TIMEOUT)
    ) dut (
        .Clk          (Clk),
        .Reset        (Reset),
        .start        (start),
        .halted       (halted),
        .wr           (wr),
        .addr         (addr),
        .core_reset   (core_reset),
        .running      (running),
        .done         (done),
        .timeout      (timeout),
        .cycles       (cycles),
        .writes       (writes),
        .last_wr_addr (last_wr_addr)
`ifdef MU0_RUN_CTRL_BREAKPOINT_EN
        ,
        .bp_valid     (bp_valid),
        .bp_addr      (bp_addr),
        .bp_hit       (bp_hit)
`endif
    );

    // Advance one clock; inputs change and outputs are sampled 1 ns after the edge.
    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic enter_run();
        pulse_start();
        step();
        step();
    endtask

    task automatic test_reset();
        #2 Reset = 1'b0;
        #1;
        n_total++; if (core_reset !== 1'b1) $display("FAIL reset_core_reset: got %b want 1", core_reset); else n_pass++;
        n_total++; if ({running, done, timeout} !== 3'b000) $display("FAIL reset_flags: got %b want 000", {running, done, timeout}); else n_pass++;
        n_total++; if (cycles !== 16'd0 || writes !== 16'd0 || last_wr_addr !== 12'h000)
            $display("FAIL reset_counters: got %0d/%0d/%h want 0/0/000", cycles, writes, last_wr_addr); else n_pass++;
        step(); step();
        Reset = 1'b1;
        step(); step(); step();
        n_total++; if (core_reset !== 1'b1 || cycles !== 16'd0 || writes !== 16'd0 || done !== 1'b0)
            $display("FAIL idle_no_start: got cr=%b cyc=%0d wr=%0d done=%b want 1/0/0/0", core_reset, cycles, writes, done); else n_pass++;
    endtask

    task automatic test_run_halt();
        pulse_start();
        n_total++; if (core_reset !== 1'b1 || running !== 1'b0) $display("FAIL rst_core_edge1: got cr=%b run=%b want 1/0", core_reset, running); else n_pass++;
        step();
        n_total++; if (core_reset !== 1'b1 || running !== 1'b0) $display("FAIL rst_core_edge2: got cr=%b run=%b want 1/0", core_reset, running); else n_pass++;
        step();
        n_total++; if (core_reset !== 1'b0 || running !== 1'b1) $display("FAIL release_edge3: got cr=%b run=%b want 0/1", core_reset, running); else n_pass++;
        for (int i = 0; i < 34; i++) step();
        halted = 1'b1;
        step();
        halted = 1'b0;
        n_total++; if (done !== 1'b1 || running !== 1'b0 || timeout !== 1'b0)
            $display("FAIL halt_flags: got done=%b run=%b tmo=%b want 1/0/0", done, running, timeout); else n_pass++;
        n_total++; if (cycles !== 16'd34) $display("FAIL halt_cycles: got %0d want 34", cycles); else n_pass++;
        n_total++; if (core_reset !== 1'b0) $display("FAIL done_core_reset: got %b want 0", core_reset); else n_pass++;
        step(); step();
        n_total++; if (cycles !== 16'd34 || done !== 1'b1) $display("FAIL done_frozen: got cyc=%0d done=%b want 34/1", cycles, done); else n_pass++;
    endtask

    task automatic test_writes();
        pulse_start();
        n_total++; if (cycles !== 16'd0 || done !== 1'b0 || core_reset !== 1'b1)
            $display("FAIL restart_clear: got cyc=%0d done=%b cr=%b want 0/0/1", cycles, done, core_reset); else n_pass++;
        step(); step();
        addr = 12'h010; step();
        wr = 1'b1; addr = 12'h0FE; step();
        wr = 1'b0; addr = 12'h011; step();
        wr = 1'b1; addr = 12'h0FF; step();
        wr = 1'b0; addr = 12'h012; halted = 1'b1; step();
        halted = 1'b0;
        n_total++; if (writes !== 16'd2 || last_wr_addr !== 12'h0FF || done !== 1'b1)
            $display("FAIL store_prog: got wr=%0d last=%h done=%b want 2/0ff/1", writes, last_wr_addr, done); else n_pass++;
        n_total++; if (cycles !== 16'd4) $display("FAIL store_cycles: got %0d want 4", cycles); else n_pass++;
        wr = 1'b1; addr = 12'h123; step(); step();
        wr = 1'b0;
        n_total++; if (writes !== 16'd2 || last_wr_addr !== 12'h0FF)
            $display("FAIL wr_outside_run: got wr=%0d last=%h want 2/0ff", writes, last_wr_addr); else n_pass++;
    endtask

    task automatic test_timeout();
        enter_run();
        for (int i = 0; i < TIMEOUT - 1; i++) step();
        n_total++; if (running !== 1'b1 || cycles !== 16'd49) $display("FAIL pre_timeout: got run=%b cyc=%0d want 1/49", running, cycles); else n_pass++;
        wr = 1'b1; addr = 12'h0AB; step();
        wr = 1'b0;
        n_total++; if (done !== 1'b1 || timeout !== 1'b1 || core_reset !== 1'b0)
            $display("FAIL timeout_flags: got done=%b tmo=%b cr=%b want 1/1/0", done, timeout, core_reset); else n_pass++;
        n_total++; if (cycles !== 16'd50) $display("FAIL timeout_cycles: got %0d want 50", cycles); else n_pass++;
        n_total++; if (writes !== 16'd1 || last_wr_addr !== 12'h0AB)
            $display("FAIL term_edge_write: got wr=%0d last=%h want 1/0ab", writes, last_wr_addr); else n_pass++;
    endtask

    task automatic test_edge_cases();
        pulse_start();
        n_total++; if (timeout !== 1'b0 || cycles !== 16'd0 || writes !== 16'd0 || last_wr_addr !== 12'h000)
            $display("FAIL done_start_clear: got tmo=%b cyc=%0d wr=%0d last=%h want 0/0/0/000", timeout, cycles, writes, last_wr_addr); else n_pass++;
        start = 1'b1; step(); start = 1'b0;
        n_total++; if (core_reset !== 1'b1 || running !== 1'b0) $display("FAIL start_in_rst_core: got cr=%b run=%b want 1/0", core_reset, running); else n_pass++;
        step();
        n_total++; if (running !== 1'b1 || core_reset !== 1'b0) $display("FAIL rst_core_not_reloaded: got run=%b cr=%b want 1/0", running, core_reset); else n_pass++;
        for (int i = 0; i < 9; i++) step();
        start = 1'b1; step(); start = 1'b0;
        n_total++; if (running !== 1'b1 || cycles !== 16'd10) $display("FAIL start_in_run: got run=%b cyc=%0d want 1/10", running, cycles); else n_pass++;
        for (int i = 0; i < 39; i++) step();
        halted = 1'b1; step(); halted = 1'b0;
        n_total++; if (done !== 1'b1 || timeout !== 1'b0 || cycles !== 16'd49)
            $display("FAIL halt_beats_timeout: got done=%b tmo=%b cyc=%0d want 1/0/49", done, timeout, cycles); else n_pass++;
    endtask

    task automatic test_mid_reset();
        enter_run();
        for (int i = 0; i < 10; i++) begin
            wr = (i == 3 || i == 4); addr = 12'h0CD; step();
        end
        wr = 1'b0;
        n_total++; if (running !== 1'b1 || cycles !== 16'd10 || writes !== 16'd2)
            $display("FAIL mid_run_state: got run=%b cyc=%0d wr=%0d want 1/10/2", running, cycles, writes); else n_pass++;
        #2 Reset = 1'b0;
        #1;
        n_total++; if (core_reset !== 1'b1 || running !== 1'b0 || done !== 1'b0)
            $display("FAIL async_abort_flags: got cr=%b run=%b done=%b want 1/0/0", core_reset, running, done); else n_pass++;
        n_total++; if (cycles !== 16'd0 || writes !== 16'd0 || last_wr_addr !== 12'h000)
            $display("FAIL async_abort_counters: got %0d/%0d/%h want 0/0/000", cycles, writes, last_wr_addr); else n_pass++;
        step();
        Reset = 1'b1;
        step();
        n_total++; if (core_reset !== 1'b1 || running !== 1'b0) $display("FAIL post_reset_idle: got cr=%b run=%b want 1/0", core_reset, running); else n_pass++;
    endtask

`ifdef MU0_RUN_CTRL_BREAKPOINT_EN
    task automatic test_breakpoint();
        bp_valid = 1'b1; bp_addr = 12'h005;
        enter_run();
        for (int k = 0; k < 5; k++) begin
            addr = 12'(k); step();
        end
        n_total++; if (bp_hit !== 1'b0 || running !== 1'b1) $display("FAIL bp_before: got hit=%b run=%b want 0/1", bp_hit, running); else n_pass++;
        addr = 12'h005; step();
        n_total++; if (bp_hit !== 1'b1 || done !== 1'b1 || timeout !== 1'b0 || cycles !== 16'd5)
            $display("FAIL bp_stop: got hit=%b done=%b tmo=%b cyc=%0d want 1/1/0/5", bp_hit, done, timeout, cycles); else n_pass++;
        bp_valid = 1'b0; addr = 12'h000;
        pulse_start();
        n_total++; if (bp_hit !== 1'b0) $display("FAIL bp_clear_on_start: got %b want 0", bp_hit); else n_pass++;
    endtask
`endif

    initial begin
        test_reset();
        test_run_halt();
        test_writes();
        test_timeout();
        test_edge_cases();
        test_mid_reset();
`ifdef MU0_RUN_CTRL_BREAKPOINT_EN
        test_breakpoint();
`endif
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
